// File: rtl/field_dispatch_pkg.sv
// Constants shared by the field dispatcher, merge FSM and decode engines.
package field_dispatch_pkg;

    localparam int IDX_W = 10;

    localparam logic [2:0] WT_VARINT    = 3'd0;
    localparam logic [2:0] WT_FIXED64   = 3'd1;
    localparam logic [2:0] WT_LEN_DELIM = 3'd2;
    localparam logic [2:0] WT_FIXED32   = 3'd5;

    localparam logic [9:0] LEN_FIXED64 = 10'd8;
    localparam logic [9:0] LEN_FIXED32 = 10'd4;

    function automatic logic wt_supported(input logic [2:0] wt);
        return (wt == WT_VARINT) || (wt == WT_FIXED64) ||
               (wt == WT_LEN_DELIM) || (wt == WT_FIXED32);
    endfunction

    function automatic logic [9:0] raw_len_of(
        input logic [2:0] wt,
        input logic [9:0] len
    );
        if (wt == WT_FIXED64) return LEN_FIXED64;
        if (wt == WT_FIXED32) return LEN_FIXED32;
        return len;
    endfunction

endpackage

// File: rtl/field_dispatch_if.sv
// Descriptor, engine-start, retire and status bundle of the field dispatcher.
interface field_dispatch_if;
    import field_dispatch_pkg::*;

    logic             field_valid;
    logic [2:0]       field_wire_type;
    logic [9:0]       field_len;
    logic             field_last;
    logic             field_accepted;
    logic             varint_start;
    logic [IDX_W-1:0] varint_index_d;
    logic             varint_start_accepted;
    logic             raw_start;
    logic [IDX_W-1:0] raw_index_d;
    logic [9:0]       raw_len;
    logic             raw_start_accepted;
    logic             retire;
    logic             msg_done;
    logic [IDX_W-1:0] outstanding;

    modport master (
        output field_valid, field_wire_type, field_len, field_last,
        output varint_start_accepted, raw_start_accepted, retire,
        input  field_accepted, varint_start, varint_index_d,
        input  raw_start, raw_index_d, raw_len, msg_done, outstanding
    );

    modport slave (
        input  field_valid, field_wire_type, field_len, field_last,
        input  varint_start_accepted, raw_start_accepted, retire,
        output field_accepted, varint_start, varint_index_d,
        output raw_start, raw_index_d, raw_len, msg_done, outstanding
    );

endinterface

// File: rtl/field_dispatch_credit.sv
// In-flight field counter: +1 per engine start, -1 per retire, floor at 0.
module field_dispatch_credit
    import field_dispatch_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             dec,
    output logic [IDX_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [IDX_W-1:0] count_q, count_d;
    logic             dec_ok;

    // A retire with nothing in flight is spurious and must not cancel an inc.
    assign dec_ok = dec && (count_q != '0);

    always_comb begin
        count_d = count_q;
        unique case ({inc, dec_ok})
            2'b10:   count_d = count_q + IDX_W'(1);
            2'b01:   count_d = count_q - IDX_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) count_q <= '0;
        else       count_q <= count_d;
    end

    assign count = count_q;
    assign full  = count_q >= IDX_W'(MAX_OUTSTANDING);
    assign empty = count_q == '0;

endmodule

// File: rtl/field_dispatch.sv
// Field sequencer: indexes descriptors and starts varint/raw engines.
// FIELD_DISPATCH_ERR_CNT_EN adds err_count/err_pulse for bad wire types.
module field_dispatch
    import field_dispatch_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic clk,
    input  logic reset,
`ifdef FIELD_DISPATCH_ERR_CNT_EN
    output logic [15:0] err_count,
    output logic        err_pulse,
`endif
    field_dispatch_if.slave bus
);

    localparam logic [5:0] S_IDLE  = 6'b000001;
    localparam logic [5:0] S_VREQ  = 6'b000010;
    localparam logic [5:0] S_RREQ  = 6'b000100;
    localparam logic [5:0] S_STALL = 6'b001000;
    localparam logic [5:0] S_DRAIN = 6'b010000;
    localparam logic [5:0] S_DONE  = 6'b100000;

    logic [5:0]       state_q, state_d;
    logic [IDX_W-1:0] next_index_q, next_index_d;
    logic             last_q, last_d;
    logic             acc_q, acc_d;
    logic             done_q, done_d;
    logic             vstart_q, vstart_d;
    logic             rstart_q, rstart_d;
    logic [IDX_W-1:0] vidx_q, vidx_d;
    logic [IDX_W-1:0] ridx_q, ridx_d;
    logic [9:0]       rlen_q, rlen_d;
    logic             inc, full, empty;
    logic [2:0]       wt;

    assign wt = bus.field_wire_type;

    field_dispatch_credit #(
        .MAX_OUTSTANDING(MAX_OUTSTANDING)
    ) u_credit (
        .clk   (clk),
        .reset (reset),
        .inc   (inc),
        .dec   (bus.retire),
        .count (bus.outstanding),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        state_d      = state_q;
        next_index_d = next_index_q;
        last_d       = last_q;
        acc_d        = 1'b0;
        done_d       = 1'b0;
        vstart_d     = vstart_q;
        rstart_d     = rstart_q;
        vidx_d       = vidx_q;
        ridx_d       = ridx_q;
        rlen_d       = rlen_q;
        inc          = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                // acc_q guard: the consumed descriptor is still visible for a cycle
                if (bus.field_valid && !acc_q) begin
                    if (!wt_supported(wt)) begin
                        acc_d = 1'b1;
                    end else if (full) begin
                        state_d = S_STALL;
                    end else begin
                        acc_d  = 1'b1;
                        last_d = bus.field_last;
                        if (wt == WT_VARINT) begin
                            state_d  = S_VREQ;
                            vstart_d = 1'b1;
                            vidx_d   = next_index_q;
                        end else begin
                            state_d  = S_RREQ;
                            rstart_d = 1'b1;
                            ridx_d   = next_index_q;
                            rlen_d   = raw_len_of(wt, bus.field_len);
                        end
                    end
                end
            end
            S_VREQ: begin
                if (bus.varint_start_accepted) begin
                    vstart_d     = 1'b0;
                    vidx_d       = '0;
                    inc          = 1'b1;
                    next_index_d = next_index_q + IDX_W'(1);
                    state_d      = last_q ? S_DRAIN : S_IDLE;
                end
            end
            S_RREQ: begin
                if (bus.raw_start_accepted) begin
                    rstart_d     = 1'b0;
                    ridx_d       = '0;
                    rlen_d       = '0;
                    inc          = 1'b1;
                    next_index_d = next_index_q + IDX_W'(1);
                    state_d      = last_q ? S_DRAIN : S_IDLE;
                end
            end
            S_STALL: begin
                if (!full) state_d = S_IDLE;
            end
            S_DRAIN: begin
                if (empty) state_d = S_DONE;
            end
            S_DONE: begin
                done_d       = 1'b1;
                next_index_d = '0;
                state_d      = S_IDLE;
            end
            default: begin
                state_d  = S_IDLE;
                vstart_d = 1'b0;
                rstart_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            next_index_q <= '0;
            last_q       <= 1'b0;
            acc_q        <= 1'b0;
            done_q       <= 1'b0;
            vstart_q     <= 1'b0;
            rstart_q     <= 1'b0;
            vidx_q       <= '0;
            ridx_q       <= '0;
            rlen_q       <= '0;
        end else begin
            state_q      <= state_d;
            next_index_q <= next_index_d;
            last_q       <= last_d;
            acc_q        <= acc_d;
            done_q       <= done_d;
            vstart_q     <= vstart_d;
            rstart_q     <= rstart_d;
            vidx_q       <= vidx_d;
            ridx_q       <= ridx_d;
            rlen_q       <= rlen_d;
        end
    end

    assign bus.field_accepted = acc_q;
    assign bus.msg_done       = done_q;
    assign bus.varint_start   = vstart_q;
    assign bus.varint_index_d = vidx_q;
    assign bus.raw_start      = rstart_q;
    assign bus.raw_index_d    = ridx_q;
    assign bus.raw_len        = rlen_q;

`ifdef FIELD_DISPATCH_ERR_CNT_EN
    logic        bad;
    logic [15:0] err_cnt_q, err_cnt_d;
    logic        err_pulse_q;

    assign bad = (state_q == S_IDLE) && bus.field_valid &&
                 !acc_q && !wt_supported(wt);

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (bad && (err_cnt_q != 16'hFFFF)) err_cnt_d = err_cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_cnt_q   <= '0;
            err_pulse_q <= 1'b0;
        end else begin
            err_cnt_q   <= err_cnt_d;
            err_pulse_q <= bad;
        end
    end

    assign err_count = err_cnt_q;
    assign err_pulse = err_pulse_q;
`endif

endmodule

// File: tb/tb_field_dispatch.sv
// Directed bench for field_dispatch (MAX_OUTSTANDING=2).
module tb_field_dispatch;
    import field_dispatch_pkg::*;

    localparam int MAXO = 2;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    field_dispatch_if bus();

`ifdef FIELD_DISPATCH_ERR_CNT_EN
    logic [15:0] err_count;
    logic        err_pulse;
`endif

    field_dispatch #(
        .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
`ifdef FIELD_DISPATCH_ERR_CNT_EN
        .err_count (err_count),
        .err_pulse (err_pulse),
`endif
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(
        input string       tag,
        input logic [31:0] got,
        input logic [31:0] exp
    );
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic send(
        input logic [2:0] wt,
        input logic [9:0] len,
        input logic       last
    );
        logic got;
        got = 1'b0;
        bus.field_valid     = 1'b1;
        bus.field_wire_type = wt;
        bus.field_len       = len;
        bus.field_last      = last;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.field_accepted) begin
                got = 1'b1;
                break;
            end
        end
        bus.field_valid = 1'b0;
        check("send_acc", 32'(got), 32'd1);
    endtask

    task automatic take_v(input logic [9:0] idx);
        check("v_start", 32'(bus.varint_start), 32'd1);
        check("v_idx", 32'(bus.varint_index_d), 32'(idx));
        check("v_norraw", 32'(bus.raw_start), 32'd0);
        bus.varint_start_accepted = 1'b1;
        tick();
        bus.varint_start_accepted = 1'b0;
        check("v_drop", 32'(bus.varint_start), 32'd0);
    endtask

    task automatic take_r(input logic [9:0] idx, input logic [9:0] len);
        check("r_start", 32'(bus.raw_start), 32'd1);
        check("r_idx", 32'(bus.raw_index_d), 32'(idx));
        check("r_len", 32'(bus.raw_len), 32'(len));
        bus.raw_start_accepted = 1'b1;
        tick();
        bus.raw_start_accepted = 1'b0;
        check("r_drop", 32'(bus.raw_start), 32'd0);
    endtask

    task automatic retire_one();
        bus.retire = 1'b1;
        tick();
        bus.retire = 1'b0;
    endtask

    task automatic wait_done();
        logic got;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.msg_done) begin
                got = 1'b1;
                break;
            end
        end
        check("msg_done", 32'(got), 32'd1);
        tick();
        check("msg_done_pulse", 32'(bus.msg_done), 32'd0);
    endtask

    initial begin
        checks                    = 0;
        failures                  = 0;
        reset                     = 1'b1;
        bus.field_valid           = 1'b0;
        bus.field_wire_type       = 3'd0;
        bus.field_len             = 10'd0;
        bus.field_last            = 1'b0;
        bus.varint_start_accepted = 1'b0;
        bus.raw_start_accepted    = 1'b0;
        bus.retire                = 1'b0;
        tick();
        tick();
        check("rst_acc", 32'(bus.field_accepted), 32'd0);
        check("rst_vs", 32'(bus.varint_start), 32'd0);
        check("rst_rs", 32'(bus.raw_start), 32'd0);
        check("rst_done", 32'(bus.msg_done), 32'd0);
        check("rst_out", 32'(bus.outstanding), 32'd0);
        reset = 1'b0;
        tick();

        // message: varint, fixed32, len-delim(17, last)
        send(3'd0, 10'd0, 1'b0);
        take_v(10'd0);
        check("m1_out1", 32'(bus.outstanding), 32'd1);
        send(3'd5, 10'd0, 1'b0);
        take_r(10'd1, 10'd4);
        check("m1_out2", 32'(bus.outstanding), 32'd2);
        retire_one();
        send(3'd2, 10'd17, 1'b1);
        take_r(10'd2, 10'd17);
        retire_one();
        retire_one();
        wait_done();
        send(3'd0, 10'd0, 1'b1);
        take_v(10'd0);
        retire_one();
        wait_done();

        // credit limit: third varint stalls until a retire
        send(3'd0, 10'd0, 1'b0);
        take_v(10'd0);
        send(3'd0, 10'd0, 1'b0);
        take_v(10'd1);
        bus.field_valid     = 1'b1;
        bus.field_wire_type = 3'd0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("stall_acc", 32'(bus.field_accepted), 32'd0);
            check("stall_vs", 32'(bus.varint_start), 32'd0);
        end
        check("stall_out", 32'(bus.outstanding), 32'd2);
        retire_one();
        send(3'd0, 10'd0, 1'b0);
        take_v(10'd2);
        retire_one();
        retire_one();
        check("drain_out", 32'(bus.outstanding), 32'd0);

        // delayed varint accept
        send(3'd0, 10'd0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_vs", 32'(bus.varint_start), 32'd1);
            check("hold_idx", 32'(bus.varint_index_d), 32'd3);
            check("hold_out", 32'(bus.outstanding), 32'd0);
        end
        take_v(10'd3);
        check("hold_out1", 32'(bus.outstanding), 32'd1);

        // start-accept and retire together at outstanding=1
        send(3'd0, 10'd0, 1'b0);
        check("both_vs", 32'(bus.varint_start), 32'd1);
        check("both_idx", 32'(bus.varint_index_d), 32'd4);
        bus.varint_start_accepted = 1'b1;
        bus.retire                = 1'b1;
        tick();
        bus.varint_start_accepted = 1'b0;
        bus.retire                = 1'b0;
        check("both_out", 32'(bus.outstanding), 32'd1);
        retire_one();
        check("ret_out0", 32'(bus.outstanding), 32'd0);
        retire_one();
        check("ret_sat", 32'(bus.outstanding), 32'd0);

        // index wrap 1023 -> 0 -> 1
        for (int i = 5; i <= 1025; i++) begin
            send(3'd0, 10'd0, 1'b0);
            take_v(10'(i % 1024));
            retire_one();
        end

        // unsupported wire type: consumed, no start, no index
        send(3'd3, 10'd0, 1'b0);
        check("bad_vs", 32'(bus.varint_start), 32'd0);
        check("bad_rs", 32'(bus.raw_start), 32'd0);
`ifdef FIELD_DISPATCH_ERR_CNT_EN
        check("err_cnt", 32'(err_count), 32'd1);
        check("err_pulse", 32'(err_pulse), 32'd1);
`endif
        tick();
        check("bad_idle_vs", 32'(bus.varint_start), 32'd0);
        send(3'd0, 10'd0, 1'b0);
        take_v(10'd2);

        // reset while raw_start is high
        send(3'd1, 10'd99, 1'b0);
        check("rst_rs_hi", 32'(bus.raw_start), 32'd1);
        check("rst_rlen8", 32'(bus.raw_len), 32'd8);
        check("rst_ridx", 32'(bus.raw_index_d), 32'd3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mrst_rs", 32'(bus.raw_start), 32'd0);
        check("mrst_ridx", 32'(bus.raw_index_d), 32'd0);
        check("mrst_rlen", 32'(bus.raw_len), 32'd0);
        check("mrst_out", 32'(bus.outstanding), 32'd0);
        check("mrst_acc", 32'(bus.field_accepted), 32'd0);
        send(3'd0, 10'd0, 1'b0);
        take_v(10'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/field_dispatch.md
Name: field_dispatch

Overview:
- Upstream sequencer for the field decode engines.
- Accepts parsed field descriptors, tags each one with a 10-bit output sequence index, and routes it to either the varint engine or the raw-data engine.
- The downstream in-order merge FSM reassembles results by that index, so every dispatched field's index is consumed exactly once and in order.
- Limits in-flight fields and drains/resets the index at message end.

Parameters:
MAX_OUTSTANDING, 8, max dispatched-but-not-retired fields (1..1023)
IDX_W, 10, sequence index width; must equal merge FSM index width

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
field_valid  in  1  descriptor present
field_wire_type  in  3  0=varint, 1=fixed64, 2=length-delimited, 5=fixed32, others unsupported
field_len  in  10  payload bytes (raw types; ignored for varint)
field_last  in  1  descriptor is last of message
field_accepted  out  1  one-cycle pulse: descriptor consumed
varint_start  out  1  request to varint engine (held until accepted)
varint_index_d  out  IDX_W  sequence index for varint field
varint_start_accepted  in  1  varint engine took request
raw_start  out  1  request to raw-data engine (held until accepted)
raw_index_d  out  IDX_W  sequence index for raw field
raw_len  out  10  byte count (8 for fixed64, 4 for fixed32, field_len for type 2)
raw_start_accepted  in  1  raw engine took request
retire  in  1  pulse per field pushed to output FIFO by merge FSM
msg_done  out  1  one-cycle pulse: message fully drained
outstanding  out  IDX_W  current in-flight count

Behaviour:
- Reset: state IDLE, next_index=0, outstanding=0; all outputs 0.
- Registered outputs; one-hot states: IDLE, V_REQ, R_REQ, STALL, DRAIN, DONE.
- IDLE, field_valid=1:
  - Supported type and outstanding<MAX_OUTSTANDING: latch descriptor, pulse field_accepted, go V_REQ (type 0) or R_REQ (types 1/2/5).
  - Supported type and outstanding==MAX_OUTSTANDING: go STALL; no accept.
  - Unsupported type: pulse field_accepted, consume no index, stay IDLE (see Optional Feature).
- V_REQ / R_REQ:
  - Drive start high with index=next_index (and raw_len in R_REQ), held stable until the matching *_start_accepted.
  - In the accept cycle: next_index+1 (wraps 1023->0), outstanding+1.
  - Then DRAIN if the latched field_last=1, else IDLE.
- Latency: descriptor to start = 1 cycle.
- STALL: wait for outstanding<MAX_OUTSTANDING, then return to IDLE. Descriptor stays pending.
- DRAIN:
  - No new accepts.
  - When outstanding==0: go DONE.
- DONE: pulse msg_done, clear next_index to 0, go IDLE.
- Outstanding counter:
  - retire decrements.
  - Simultaneous start-accept and retire: no change.
  - retire with outstanding==0: ignored (counter saturates at 0).
- Varint and raw requests never overlap; at most one start asserted in any cycle.
- Reset mid-request drops the start immediately. The engines are reset by the same signal.
- Illegal state: go IDLE.

Optional Feature:
- Macro: FIELD_DISPATCH_ERR_CNT_EN.
- When defined:
  - Adds output err_count (16 bits, saturating at 0xFFFF, cleared by reset) and err_pulse (1 cycle).
  - Both fire on each unsupported wire type.
  - The unsupported descriptor is still consumed without an index.
- When undefined: ports absent; unsupported fields are silently dropped.

Decomposition:
- Shared package holds:
  - wire-type constants (WT_VARINT, WT_FIXED64, WT_LEN_DELIM, WT_FIXED32)
  - IDX_W
  - fixed raw lengths 8/4
- These constants are shared with the merge FSM and both engines.
- One natural sub-module: field_dispatch_credit. It holds the outstanding up/down counter with saturation and full flag.

Test Plan:
- Varint then fixed32 then len-delim(len=17, last):
  - varint_index_d=0; raw_index_d=1, raw_len=4; raw_index_d=2, raw_len=17.
  - After 3 retires: msg_done pulse; next message starts at index 0.
- MAX_OUTSTANDING=2, 3 varint fields, no retire:
  - Third stays in STALL with field_accepted low.
  - One retire: third dispatched with index 2.
- varint_start_accepted delayed 5 cycles:
  - varint_start and index held stable for all 5 cycles.
  - outstanding increments only in the accept cycle.
- Start-accept and retire in the same cycle at outstanding=1 -> outstanding stays 1.
- 1025 single-field traffic without last:
  - Index wraps 1023 -> 0 -> 1.
  - Then wire_type=3: accepted, no start; with FIELD_DISPATCH_ERR_CNT_EN, err_count=1.
- Reset asserted while raw_start is high -> next cycle: all outputs 0, outstanding=0, state IDLE.
